// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Brief    : Operand forwarding selects and load-use / taken-branch hazard
//            control for a 5-stage pipeline, with saturating event counters.
// Revision : 1.0
// ============================================================================
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic [1:0]            id_result_src,
    input  logic                  ex_branch_taken,
    output logic [2:0]            fwd_sel_a,
    output logic [2:0]            fwd_sel_b,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [1:0] c_RS_ALU  = 2'b00;
    localparam logic [1:0] c_RS_LOAD = 2'b01;
    localparam logic [1:0] c_RS_PC4  = 2'b10;

    localparam logic [2:0] c_SEL_RF  = 3'd0;
    localparam logic [2:0] c_SEL_WB  = 3'd1;
    localparam logic [2:0] c_SEL_MEM = 3'd2;
    localparam logic [2:0] c_SEL_PC4 = 3'd3;

    localparam logic [REG_ADDR_W-1:0] c_X0 = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic [1:0]            result_src;
    } e_stage_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic [1:0]            result_src;
    } m_stage_t;

    e_stage_t              r_e;
    m_stage_t              r_m;
    logic                  r_w_valid;
    logic [REG_ADDR_W-1:0] r_w_rd;
    logic                  r_w_regwrite;
    logic [CNT_W-1:0]      r_stall_count;
    logic [CNT_W-1:0]      r_flush_count;

    logic w_branch;
    logic w_lu;
    logic w_stall;
    logic w_flush_e;
    logic w_m_fwd_ok;
    logic w_w_fwd_ok;

    // Branch input is gated so flush_d reads 0 while reset is held.
    assign w_branch  = ex_branch_taken & rst_n;
    assign w_lu      = id_valid & r_e.valid & r_e.regwrite & (r_e.result_src == c_RS_LOAD) &
                       (r_e.rd != c_X0) & ((r_e.rd == id_rs1) | (r_e.rd == id_rs2));
    assign w_stall   = w_lu & ~w_branch;
    assign w_flush_e = w_lu | w_branch;

    assign w_m_fwd_ok = r_m.valid & r_m.regwrite & (r_m.rd != c_X0) & (r_m.result_src != c_RS_LOAD);
    assign w_w_fwd_ok = r_w_valid & r_w_regwrite & (r_w_rd != c_X0);

    function automatic logic [2:0] sel_for(input logic [REG_ADDR_W-1:0] rs);
        logic [2:0] v_sel;
        v_sel = c_SEL_RF;
        if (r_e.valid) begin
            if (w_m_fwd_ok && (r_m.rd == rs))
                v_sel = (r_m.result_src == c_RS_PC4) ? c_SEL_PC4 : c_SEL_MEM;
            else if (w_w_fwd_ok && (r_w_rd == rs))
                v_sel = c_SEL_WB;
        end
        return v_sel;
    endfunction

    assign fwd_sel_a   = sel_for(r_e.rs1);
    assign fwd_sel_b   = sel_for(r_e.rs2);
    assign stall_f     = w_stall;
    assign stall_d     = w_stall;
    assign flush_d     = w_branch;
    assign flush_e     = w_flush_e;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e           <= '0;
            r_m           <= '0;
            r_w_valid     <= 1'b0;
            r_w_rd        <= '0;
            r_w_regwrite  <= 1'b0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_w_valid    <= r_m.valid;
            r_w_rd       <= r_m.rd;
            r_w_regwrite <= r_m.regwrite;
            r_m.valid      <= r_e.valid;
            r_m.rd         <= r_e.rd;
            r_m.regwrite   <= r_e.regwrite;
            r_m.result_src <= r_e.result_src;
            if (w_flush_e) begin
                r_e <= '0;
            end else begin
                r_e.valid      <= id_valid;
                r_e.rs1        <= id_rs1;
                r_e.rs2        <= id_rs2;
                r_e.rd         <= id_rd;
                r_e.regwrite   <= id_regwrite;
                r_e.result_src <= id_result_src;
            end
            if (w_stall && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + CNT_W'(1);
            if (w_branch && (r_flush_count != {CNT_W{1'b1}}))
                r_flush_count <= r_flush_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Brief    : Directed scoreboard bench for fwd_hazard_unit.
// Revision : 1.0
// ============================================================================
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic [4:0]  id_rd = '0;
    logic        id_regwrite = 1'b0;
    logic [1:0]  id_result_src = '0;
    logic        ex_branch_taken = 1'b0;

    logic [2:0]  fwd_sel_a, fwd_sel_b;
    logic        stall_f, stall_d, flush_d, flush_e;
    logic [31:0] stall_count, flush_count;

    logic [2:0]  s_sel_a, s_sel_b;
    logic        s_stall_f, s_stall_d, s_flush_d, s_flush_e;
    logic [1:0]  s_stall_count, s_flush_count;

    typedef logic [73:0] vec_t;
    vec_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_result_src(id_result_src),
        .ex_branch_taken(ex_branch_taken), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Narrow-counter copy so saturation is reached in a handful of events.
    fwd_hazard_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_result_src(id_result_src),
        .ex_branch_taken(ex_branch_taken), .fwd_sel_a(s_sel_a), .fwd_sel_b(s_sel_b),
        .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_d(s_flush_d), .flush_e(s_flush_e),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic rw, input logic [1:0] rs,
                         input logic br);
        @(negedge clk);
        id_valid = v; id_rs1 = s1; id_rs2 = s2; id_rd = d;
        id_regwrite = rw; id_result_src = rs; ex_branch_taken = br;
    endtask

    task automatic check_out();
        vec_t  e;
        vec_t  obs;
        string t;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = {fwd_sel_a, fwd_sel_b, stall_f, stall_d, flush_d, flush_e, stall_count, flush_count};
        n_tests++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] a, input logic [2:0] b,
                              input logic sf, input logic sd, input logic fd, input logic fe,
                              input logic [31:0] sc, input logic [31:0] fc);
        exp_q.push_back({a, b, sf, sd, fd, fe, sc, fc});
        tag_q.push_back(tag);
        #1;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held: outputs zero even with a branch and ID activity present.
        drive(1, 0, 0, 5, 1, 2'b00, 1);
        expect_out("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 5, 1, 2'b00, 0); rst_n = 1'b1;      // add x5
        expect_out("idle", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 5, 6, 8, 1, 2'b00, 0);                    // consumer rs1=5
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        expect_out("m_alu", 2, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 2'b00, 0);                    // writes x0
        drive(1, 0, 0, 8, 1, 2'b00, 0);                    // reads x0, x0
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        expect_out("m_rd0", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 5, 1, 2'b10, 0);                    // jal x5 -> ends in W
        drive(1, 0, 0, 5, 1, 2'b00, 0);                    // add x5 -> in M
        drive(1, 5, 9, 8, 1, 2'b00, 0);
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        expect_out("mem_prio", 2, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 5, 1, 2'b10, 0);                    // jal x5 in M
        drive(1, 5, 3, 8, 1, 2'b00, 0);
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        expect_out("m_pc4", 3, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 4, 1, 2'b11, 0);                    // li x4
        drive(1, 8, 4, 8, 1, 2'b00, 0);
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        expect_out("m_imm", 0, 2, 0, 0, 0, 0, 0, 0);
        // Load-use on rs2, then the consumer picks the load up from WB.
        drive(1, 0, 0, 7, 1, 2'b01, 0);                    // lw x7
        drive(1, 3, 7, 10, 1, 2'b00, 0);
        expect_out("lu", 0, 0, 1, 1, 0, 1, 0, 0);
        drive(1, 3, 7, 10, 1, 2'b00, 0);
        expect_out("lu_bubble", 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        expect_out("lu_wb", 0, 1, 0, 0, 0, 0, 1, 0);
        // Taken branch coincident with a load-use hit.
        drive(1, 0, 0, 7, 1, 2'b01, 0);
        drive(1, 7, 0, 10, 1, 2'b00, 1);
        expect_out("br_lu", 0, 0, 0, 0, 1, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        expect_out("br_after", 0, 0, 0, 0, 0, 0, 1, 1);
        // Asynchronous reset mid-cycle.
        drive(1, 0, 0, 5, 1, 2'b00, 0);
        drive(1, 5, 6, 8, 1, 2'b00, 0);
        drive(0, 0, 0, 0, 0, 2'b00, 1);
        expect_out("pre_rst", 2, 0, 0, 0, 1, 1, 1, 1);
        #2 rst_n = 1'b0;
        expect_out("rst_async", 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        drive(1, 0, 0, 5, 1, 2'b00, 0); rst_n = 1'b1;
        expect_out("rel_c0", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 5, 6, 8, 1, 2'b00, 0);
        expect_out("rel_c1", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        expect_out("rel_c2", 2, 0, 0, 0, 0, 0, 0, 0);
        // Back-to-back dependent loads: a load-use stall every other cycle.
        for (int k = 0; k < 8; k++) drive(1, 7, 0, 7, 1, 2'b01, 0);
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        expect_out("lu_x4", 0, 0, 0, 0, 0, 0, 4, 0);
        n_tests++;
        assert (s_stall_count === 2'b11) else begin
            n_fail++;
            $error("FAIL sat_stall observed=%0d expected=%0d", s_stall_count, 3);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
